// File: rtl/mx_apb_master_bridge.sv
// Bridge from a valid/ready register-access stream to APB3 master signals, with a
// divided APB clock-enable strobe, a response channel and an ACCESS-phase timeout.
module mx_apb_master_bridge #(
    parameter int unsigned CLKDIV  = 2,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        PClkxCI,
    input  logic        PResetxRBI,
    input  logic        ReqValidxSI,
    output logic        ReqReadyxSO,
    input  logic        ReqWritexSI,
    input  logic [31:2] ReqAddrxDI,
    input  logic [31:0] ReqWDataxDI,
    output logic        RspValidxSO,
    input  logic        RspReadyxSI,
    output logic [31:0] RspRDataxDO,
    output logic        RspErrxSO,
    output logic        RspTimeoutxSO,
    output logic        PEnClkxSO,
    output logic        PSelxSO,
    output logic        PEnablexSO,
    output logic        PWritexSO,
    output logic [31:2] PAddrxDO,
    output logic [31:0] PWDataxDO,
    input  logic        PReadyxSI,
    input  logic [31:0] PRDataxDI,
    input  logic        PSlverrxSI
);

    localparam int unsigned DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PEND,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              pen_q, pen_d;
    logic              req_rdy_q, req_rdy_d;
    logic              wr_q, wr_d;
    logic [31:2]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [31:2]       paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_to_q, rsp_to_d;

    // Next-state, divider and output computation
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        to_cnt_d    = to_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;

        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        pen_d = (div_d == DIV_LAST);

        unique case (state_q)
            S_IDLE: begin
                if (ReqValidxSI && req_rdy_q) begin
                    wr_d    = ReqWritexSI;
                    addr_d  = ReqAddrxDI;
                    wdata_d = ReqWDataxDI;
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                if (pen_q) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = wr_q;
                    paddr_d   = addr_q;
                    pwdata_d  = wdata_q;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (pen_q) begin
                    penable_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (pen_q) begin
                    if (PReadyxSI) begin
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = wr_q ? 32'h0 : PRDataxDI;
                        rsp_err_d   = PSlverrxSI;
                        rsp_to_d    = 1'b0;
                        state_d     = S_RESP;
                    end else if (to_cnt_q == TO_LAST) begin
                        // Hung slave: abort the transfer and report it
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                        rsp_err_d   = 1'b1;
                        rsp_to_d    = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
            S_RESP: begin
                if (RspReadyxSI) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Ready only once IDLE has been held a full cycle, which blocks the RESP->IDLE handover
        req_rdy_d = (state_q == S_IDLE) && (state_d == S_IDLE);
    end

    always_ff @(posedge PClkxCI) begin
        if (!PResetxRBI) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            pen_q       <= 1'b0;
            req_rdy_q   <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            to_cnt_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            pen_q       <= pen_d;
            req_rdy_q   <= req_rdy_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            to_cnt_q    <= to_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign ReqReadyxSO   = req_rdy_q;
    assign RspValidxSO   = rsp_valid_q;
    assign RspRDataxDO   = rsp_rdata_q;
    assign RspErrxSO     = rsp_err_q;
    assign RspTimeoutxSO = rsp_to_q;
    assign PEnClkxSO     = pen_q;
    assign PSelxSO       = psel_q;
    assign PEnablexSO    = penable_q;
    assign PWritexSO     = pwrite_q;
    assign PAddrxDO      = paddr_q;
    assign PWDataxDO     = pwdata_q;

endmodule

// File: tb/tb_mx_apb_master_bridge.sv
// Bench for mx_apb_master_bridge: two instances (CLKDIV=1 and CLKDIV=4, TIMEOUT=8)
// driven with directed and random transfers against a transaction-level reference model.
module tb_mx_apb_master_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_write;
    logic [31:2] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  rsp_valid, rsp_ready, rsp_err, rsp_to;
    logic [31:0] rsp_rdata [2];
    logic [1:0]  pen, psel, penable, pwrite, pready, pslverr;
    logic [31:2] paddr [2];
    logic [31:0] pwdata [2];
    logic [31:0] prdata [2];

    int          slv_wait [2];
    logic [31:0] slv_rdata [2];
    logic [1:0]  slv_err;
    int          acc_cnt [2] = '{0, 0};

    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_u
        mx_apb_master_bridge #(.CLKDIV(g == 0 ? 1 : 4), .TIMEOUT(TO)) u_dut (
            .PClkxCI      (clk),
            .PResetxRBI   (rst_n),
            .ReqValidxSI  (req_valid[g]),
            .ReqReadyxSO  (req_ready[g]),
            .ReqWritexSI  (req_write[g]),
            .ReqAddrxDI   (req_addr[g]),
            .ReqWDataxDI  (req_wdata[g]),
            .RspValidxSO  (rsp_valid[g]),
            .RspReadyxSI  (rsp_ready[g]),
            .RspRDataxDO  (rsp_rdata[g]),
            .RspErrxSO    (rsp_err[g]),
            .RspTimeoutxSO(rsp_to[g]),
            .PEnClkxSO    (pen[g]),
            .PSelxSO      (psel[g]),
            .PEnablexSO   (penable[g]),
            .PWritexSO    (pwrite[g]),
            .PAddrxDO     (paddr[g]),
            .PWDataxDO    (pwdata[g]),
            .PReadyxSI    (pready[g]),
            .PRDataxDI    (prdata[g]),
            .PSlverrxSI   (pslverr[g])
        );
        // Slave: raise PREADY once slv_wait not-ready ACCESS APB edges have passed
        assign pready[g]  = psel[g] && penable[g] && (acc_cnt[g] >= slv_wait[g]);
        assign prdata[g]  = slv_rdata[g];
        assign pslverr[g] = slv_err[g];
    end

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (psel[u] && penable[u]) begin
                if (pen[u] && !pready[u]) acc_cnt[u] <= acc_cnt[u] + 1;
            end else begin
                acc_cnt[u] <= 0;
            end
        end
    end

    // Any APB output change across a non-APB edge is recorded as a violation
    logic [64:0] mon_snap [2];
    logic [64:0] mon_cur [2];
    logic [1:0]  mon_pen = 2'b00;
    logic [1:0]  mon_ok = 2'b00;
    int          viol [2] = '{0, 0};

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            mon_cur[u] = {psel[u], penable[u], pwrite[u], paddr[u], pwdata[u]};
            if (rst_n && mon_ok[u] && !mon_pen[u] && (mon_cur[u] != mon_snap[u])) viol[u]++;
            mon_snap[u] = mon_cur[u];
            mon_pen[u]  = pen[u];
            mon_ok[u]   = rst_n;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer with response-side checks; expectations come from the transfer rules
    task automatic do_txn(input int u, input bit wr, input logic [31:2] addr, input logic [31:0] wd,
                          input int wt, input logic [31:0] rd, input bit er, input int dly);
        int          n;
        int          edges;
        bit          exp_to;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [34:0] hold;
        slv_wait[u]  = wt;
        slv_rdata[u] = rd;
        slv_err[u]   = er;
        req_valid[u] = 1'b1;
        req_write[u] = wr;
        req_addr[u]  = addr;
        req_wdata[u] = wd;
        n = 0;
        while (!req_ready[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", 128'(n < 200), 128'(1));
        @(negedge clk);
        req_valid[u] = 1'b0;

        exp_to  = (wt >= TO);
        edges   = exp_to ? TO : wt + 1;
        exp_err = exp_to || er;
        exp_rd  = (exp_to || wr) ? 32'h0 : rd;

        n = 0;
        while (!rsp_valid[u] && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", 128'(n < 400), 128'(1));
        if (u == 0) chk("latency_div1", 128'(n), 128'(2 + edges));
        else        chk("latency_div4", 128'((n >= 5 + 4 * edges) && (n <= 8 + 4 * edges)), 128'(1));
        chk("rsp_rdata", 128'(rsp_rdata[u]), 128'(exp_rd));
        chk("rsp_err", 128'(rsp_err[u]), 128'(exp_err));
        chk("rsp_timeout", 128'(rsp_to[u]), 128'(exp_to));
        chk("apb_idle_hold", 128'({psel[u], penable[u], pwrite[u], paddr[u], pwdata[u]}),
            128'({2'b00, wr, addr, wd}));

        hold = {rsp_valid[u], rsp_err[u], rsp_to[u], rsp_rdata[u]};
        for (int d = 0; d < dly; d++) begin
            @(negedge clk);
            chk("rsp_stable", 128'({rsp_valid[u], rsp_err[u], rsp_to[u], rsp_rdata[u]}), 128'(hold));
            chk("req_ready_busy", 128'(req_ready[u]), 128'(0));
        end
        rsp_ready[u] = 1'b1;
        @(negedge clk);
        rsp_ready[u] = 1'b0;
        chk("rsp_valid_drop", 128'(rsp_valid[u]), 128'(0));
        chk("handover_not_ready", 128'(req_ready[u]), 128'(0));
    endtask

    initial begin
        int n;
        int ones0;
        int ones1;
        int last1;
        int seen;
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        rsp_ready = '0;
        slv_err   = '0;
        for (int u = 0; u < 2; u++) begin
            req_addr[u]  = '0;
            req_wdata[u] = '0;
            slv_wait[u]  = 0;
            slv_rdata[u] = '0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++)
            chk("reset_outputs", 128'({req_ready[u], rsp_valid[u], rsp_rdata[u], rsp_err[u], rsp_to[u],
                pen[u], psel[u], penable[u], pwrite[u], paddr[u], pwdata[u]}), 128'(0));
        rst_n = 1'b1;

        // Enable strobe: always high for CLKDIV=1, one pulse per 4 cycles for CLKDIV=4
        ones0 = 0;
        ones1 = 0;
        last1 = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (pen[0]) ones0++;
            if (pen[1]) begin
                ones1++;
                if (last1 >= 0) chk("pen_div4_period", 128'(c - last1), 128'(4));
                last1 = c;
            end
        end
        chk("pen_div1_count", 128'(ones0), 128'(16));
        chk("pen_div4_count", 128'(ones1), 128'(4));

        // Directed transfers
        do_txn(0, 1'b1, 30'h10, 32'h1234_5678, 0, 32'hDEAD_BEEF, 1'b0, 0);
        do_txn(1, 1'b0, 30'h4, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 1);
        do_txn(0, 1'b0, 30'h20, 32'h0, 0, 32'hA5A5_0001, 1'b1, 0);
        do_txn(0, 1'b0, 30'h21, 32'h0, TO, 32'h1111_2222, 1'b0, 0);
        do_txn(0, 1'b0, 30'h22, 32'h0, TO - 1, 32'h3333_4444, 1'b0, 0);
        do_txn(1, 1'b1, 30'h23, 32'h5555_6666, TO, 32'h0, 1'b0, 0);
        do_txn(1, 1'b0, 30'h24, 32'h0, TO - 1, 32'h7777_8888, 1'b1, 0);
        do_txn(0, 1'b1, 30'h30, 32'h0BAD_CAFE, 1, 32'h0, 1'b0, 10);
        do_txn(0, 1'b0, 30'h31, 32'h0, 0, 32'h9999_AAAA, 1'b0, 0);
        do_txn(0, 1'b1, 30'h32, 32'hBBBB_CCCC, 0, 32'h0, 1'b0, 0);

        // Reset asserted while a CLKDIV=4 transfer sits in ACCESS
        slv_wait[1]  = 100;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 30'h3FF;
        n = 0;
        while (!req_ready[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        n = 0;
        while (!(psel[1] && penable[1]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_access", 128'(psel[1] && penable[1]), 128'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs", 128'({psel[1], penable[1], rsp_valid[1], req_ready[1]}), 128'(0));
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (rsp_valid[1]) seen++;
        end
        chk("no_rsp_after_reset", 128'(seen), 128'(0));
        chk("ready_after_reset", 128'(req_ready[1]), 128'(1));

        // Random transfers
        for (int i = 0; i < 40; i++) begin
            do_txn(int'($urandom_range(0, 1)), 1'($urandom), 30'($urandom), $urandom,
                   int'($urandom_range(0, TO + 1)), $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        chk("apb_edge_only_div1", 128'(viol[0]), 128'(0));
        chk("apb_edge_only_div4", 128'(viol[1]), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
